// File: rtl/gte_mac_accum_if.sv
// rtl/gte_mac_accum_if.sv - command, product-term and result bundle for gte_mac_accum
interface gte_mac_accum_if;
  logic        i_start;
  logic [31:0] i_base0;
  logic [31:0] i_base1;
  logic [31:0] i_base2;
  logic        i_sf;
  logic        i_lm;
  logic        i_rtp;
  logic        i_termValid;
  logic        i_last;
  logic [34:0] i_term0;
  logic [34:0] i_term1;
  logic [34:0] i_term2;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_mac0;
  logic [31:0] o_mac1;
  logic [31:0] o_mac2;
  logic [15:0] o_ir0;
  logic [15:0] o_ir1;
  logic [15:0] o_ir2;
  logic [31:0] o_flags;

  modport master (
    output i_start, i_base0, i_base1, i_base2, i_sf, i_lm, i_rtp,
           i_termValid, i_last, i_term0, i_term1, i_term2,
    input  o_busy, o_done, o_mac0, o_mac1, o_mac2, o_ir0, o_ir1, o_ir2, o_flags
  );

  modport slave (
    input  i_start, i_base0, i_base1, i_base2, i_sf, i_lm, i_rtp,
           i_termValid, i_last, i_term0, i_term1, i_term2,
    output o_busy, o_done, o_mac0, o_mac1, o_mac2, o_ir0, o_ir1, o_ir2, o_flags
  );
endinterface

// File: rtl/gte_mac_accum.sv
// rtl/gte_mac_accum.sv - GTE MAC1..3 accumulate, shift and IR saturate; optional GTE_MAC_RTP_IR3_QUIRK_EN
module gte_mac_accum #(
  parameter int ACC_W  = 44,
  parameter int TERM_W = 35
) (
  input logic             i_clk,
  input logic             i_rst,
  gte_mac_accum_if.slave  bus
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT, S_DONE} state_e;

  state_e                    state_q;
  logic signed [ACC_W-1:0]   acc_q  [3];
  logic [31:0]               mac_q  [3];
  logic [15:0]               ir_q   [3];
  // bit 8..0 map to FLAG bits 30..22
  logic [8:0]                flag_q;
  logic                      sf_q;
  logic                      lm_q;
  logic                      busy_q;
  logic                      done_q;
`ifdef GTE_MAC_RTP_IR3_QUIRK_EN
  logic                      rtp_q;
`endif

  logic [TERM_W-1:0]         term_w [3];
  logic [31:0]               base_w [3];
  logic [SUM_W-1:0]          sum_d  [3];
  logic                      ovf_p_d[3];
  logic                      ovf_n_d[3];
  logic [31:0]               mac_d  [3];
  logic [15:0]               ir_d   [3];
  logic                      clip_d [3];
  logic                      ir3_flag_d;

  assign term_w[0] = bus.i_term0;
  assign term_w[1] = bus.i_term1;
  assign term_w[2] = bus.i_term2;
  assign base_w[0] = bus.i_base0;
  assign base_w[1] = bus.i_base1;
  assign base_w[2] = bus.i_base2;

  // Per lane: widened add with overflow detect, shift select and IR clamp
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      sum_d[n]   = {acc_q[n][ACC_W-1], acc_q[n]}
                 + {{(SUM_W-TERM_W){term_w[n][TERM_W-1]}}, term_w[n]};
      ovf_p_d[n] = ~sum_d[n][SUM_W-1] &  sum_d[n][ACC_W-1];
      ovf_n_d[n] =  sum_d[n][SUM_W-1] & ~sum_d[n][ACC_W-1];
      // acc >>> 12 truncated to 32 bits is exactly bits 43..12
      mac_d[n]   = sf_q ? acc_q[n][12 +: 32] : acc_q[n][31:0];
      if ($signed(mac_d[n]) > 32'sd32767) begin
        ir_d[n]   = 16'h7FFF;
        clip_d[n] = 1'b1;
      end else if (lm_q && mac_d[n][31]) begin
        ir_d[n]   = 16'h0000;
        clip_d[n] = 1'b1;
      end else if (!lm_q && ($signed(mac_d[n]) < -32'sd32768)) begin
        ir_d[n]   = 16'h8000;
        clip_d[n] = 1'b1;
      end else begin
        ir_d[n]   = mac_d[n][15:0];
        clip_d[n] = 1'b0;
      end
    end
`ifdef GTE_MAC_RTP_IR3_QUIRK_EN
    // RTPS/RTPT judge IR3 saturation on the >>12 value, ignoring sf and lm
    ir3_flag_d = rtp_q ? (($signed(acc_q[2][12 +: 32]) > 32'sd32767) ||
                          ($signed(acc_q[2][12 +: 32]) < -32'sd32768))
                       : clip_d[2];
`else
    ir3_flag_d = clip_d[2];
`endif
  end

  // Command FSM: start/abort, accumulate, saturate, one-cycle done pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      flag_q  <= '0;
      sf_q    <= 1'b0;
      lm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GTE_MAC_RTP_IR3_QUIRK_EN
      rtp_q   <= 1'b0;
`endif
      for (int n = 0; n < 3; n++) begin
        acc_q[n] <= '0;
        mac_q[n] <= '0;
        ir_q[n]  <= '0;
      end
    end else if (bus.i_start) begin
      state_q <= S_ACC;
      flag_q  <= '0;
      sf_q    <= bus.i_sf;
      lm_q    <= bus.i_lm;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef GTE_MAC_RTP_IR3_QUIRK_EN
      rtp_q   <= bus.i_rtp;
`endif
      for (int n = 0; n < 3; n++) begin
        acc_q[n] <= {base_w[n], 12'h000};
      end
    end else begin
      case (state_q)
        S_ACC: begin
          if (bus.i_termValid) begin
            for (int n = 0; n < 3; n++) begin
              acc_q[n] <= sum_d[n][ACC_W-1:0];
              if (ovf_p_d[n]) flag_q[8-2*n] <= 1'b1;
              if (ovf_n_d[n]) flag_q[7-2*n] <= 1'b1;
            end
            if (bus.i_last) state_q <= S_SAT;
          end
        end
        S_SAT: begin
          for (int n = 0; n < 3; n++) begin
            mac_q[n] <= mac_d[n];
            ir_q[n]  <= ir_d[n];
          end
          if (clip_d[0]) flag_q[2] <= 1'b1;
          if (clip_d[1]) flag_q[1] <= 1'b1;
          if (ir3_flag_d) flag_q[0] <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_mac0  = mac_q[0];
  assign bus.o_mac1  = mac_q[1];
  assign bus.o_mac2  = mac_q[2];
  assign bus.o_ir0   = ir_q[0];
  assign bus.o_ir1   = ir_q[1];
  assign bus.o_ir2   = ir_q[2];
  assign bus.o_flags = {1'b0, flag_q, 22'h000000};

endmodule

// File: tb/tb_gte_mac_accum.sv
// tb/tb_gte_mac_accum.sv - vector table, corner sequences and randomized model check for gte_mac_accum
module tb_gte_mac_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gte_mac_accum_if bus ();

  gte_mac_accum dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic signed [34:0] tq0[$];
  logic signed [34:0] tq1[$];
  logic signed [34:0] tq2[$];

  logic [31:0] exp_mac[3];
  logic [15:0] exp_ir[3];
  logic [31:0] exp_flags;

  typedef struct {
    logic [31:0] b0, b1, b2;
    longint      t0, t1, t2;
    int          nt;
    logic        sf, lm, rtp;
    logic [31:0] m0, m1, m2;
    logic [15:0] r0, r1, r2;
    logic [31:0] fl;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic signed [34:0] term_at(input int n, input int i);
    case (n)
      0:       return tq0[i];
      1:       return tq1[i];
      default: return tq2[i];
    endcase
  endfunction

  function automatic longint wrap44(input longint v);
    longint m;
    m = v & ((64'sd1 <<< 44) - 64'sd1);
    if (m >= (64'sd1 <<< 43)) m = m - (64'sd1 <<< 44);
    return m;
  endfunction

  // Arithmetic reference: 64-bit integers, explicit range tests, modular wrap
  function automatic void model(input logic signed [31:0] b0, input logic signed [31:0] b1,
                                input logic signed [31:0] b2, input logic sf, input logic lm,
                                input logic rtp);
    logic signed [31:0] bb[3];
    longint acc, v, s, q;
    int m, lo, ir;
    logic [31:0] fl;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    fl = '0;
    for (int n = 0; n < 3; n++) begin
      acc = longint'(bb[n]) * 64'sd4096;
      for (int i = 0; i < tq0.size(); i++) begin
        v = acc + longint'(term_at(n, i));
        if (v > (64'sd1 <<< 43) - 64'sd1) fl[30-2*n] = 1'b1;
        if (v < -(64'sd1 <<< 43))         fl[29-2*n] = 1'b1;
        acc = wrap44(v);
      end
      s  = sf ? (acc >>> 12) : acc;
      m  = int'(s[31:0]);
      lo = lm ? 0 : -32768;
      if (m > 32767) begin
        ir = 32767; fl[24-n] = 1'b1;
      end else if (m < lo) begin
        ir = lo; fl[24-n] = 1'b1;
      end else begin
        ir = m;
      end
      q = acc >>> 12;
      if (n == 2 && rtp) begin
`ifdef GTE_MAC_RTP_IR3_QUIRK_EN
        fl[22] = (q > 32767) || (q < -32768);
`endif
      end
      exp_mac[n] = s[31:0];
      exp_ir[n]  = ir[15:0];
    end
    exp_flags = fl;
  endfunction

  function automatic logic [34:0] rnd_term();
    logic [34:0] r;
    int mode;
    mode = $urandom_range(0, 2);
    r[31:0]  = $urandom();
    r[34:32] = 3'($urandom_range(0, 7));
    if (mode == 1) r = 35'($signed($urandom_range(0, 32'h3FFFF)) - 32'sh20000);
    if (mode == 2) r = {r[34], {34{~r[34]}}};
    return r;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_mac0"},  bus.o_mac0, exp_mac[0]);
    check({tag, "_mac1"},  bus.o_mac1, exp_mac[1]);
    check({tag, "_mac2"},  bus.o_mac2, exp_mac[2]);
    check({tag, "_ir0"},   {16'h0, bus.o_ir0}, {16'h0, exp_ir[0]});
    check({tag, "_ir1"},   {16'h0, bus.o_ir1}, {16'h0, exp_ir[1]});
    check({tag, "_ir2"},   {16'h0, bus.o_ir2}, {16'h0, exp_ir[2]});
    check({tag, "_flags"}, bus.o_flags, exp_flags);
  endtask

  // Issue a command from the term queues; optional idle gaps carry i_last=1 with no valid
  task automatic run_cmd(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                         input logic sf, input logic lm, input logic rtp,
                         input int max_gap, input string tag);
    int gap;
    bus.i_start = 1'b1;
    bus.i_base0 = b0; bus.i_base1 = b1; bus.i_base2 = b2;
    bus.i_sf = sf; bus.i_lm = lm; bus.i_rtp = rtp;
    bus.i_termValid = 1'b0; bus.i_last = 1'b0;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < tq0.size(); i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) begin
        bus.i_termValid = 1'b0;
        bus.i_last  = 1'($urandom_range(0, 1));
        bus.i_term0 = rnd_term();
        tick();
      end
      bus.i_termValid = 1'b1;
      bus.i_last  = (i == tq0.size() - 1);
      bus.i_term0 = term_at(0, i);
      bus.i_term1 = term_at(1, i);
      bus.i_term2 = term_at(2, i);
      tick();
    end
    bus.i_termValid = 1'b0;
    bus.i_last = 1'b0;
    check({tag, "_done_early"}, {31'b0, bus.o_done}, 32'd0);
    check({tag, "_busy_sat"},   {31'b0, bus.o_busy}, 32'd1);
    tick();
    check({tag, "_done"}, {31'b0, bus.o_done}, 32'd1);
    check_results(tag);
    tick();
    check({tag, "_done_clr"}, {31'b0, bus.o_done}, 32'd0);
    check({tag, "_busy_clr"}, {31'b0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_base0 = '0; bus.i_base1 = '0; bus.i_base2 = '0;
    bus.i_sf = 1'b0; bus.i_lm = 1'b0; bus.i_rtp = 1'b0;
    bus.i_termValid = 1'b0; bus.i_last = 1'b0;
    bus.i_term0 = '0; bus.i_term1 = '0; bus.i_term2 = '0;
    tick(); tick();
    check("rst_mac0",  bus.o_mac0, 32'd0);
    check("rst_ir2",   {16'h0, bus.o_ir2}, 32'd0);
    check("rst_flags", bus.o_flags, 32'd0);
    check("rst_busy",  {31'b0, bus.o_busy}, 32'd0);
    check("rst_done",  {31'b0, bus.o_done}, 32'd0);
    rst = 1'b0;
    tick();

    vecs[0] = '{32'h0, 32'h0, 32'h0, 64'h1000000, 64'h1000000, 64'h1000000, 3, 1'b1, 1'b0, 1'b0,
                32'd12288, 32'd12288, 32'd12288, 16'h3000, 16'h3000, 16'h3000, 32'h0};
    vecs[1] = '{32'h7FFFFFFF, 32'h0, 32'h0, 64'h1000, 64'h0, 64'h0, 1, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 32'h40000000};
    vecs[2] = '{32'h0, 32'h0, 32'h0, -64'sd4096, 64'h0, 64'h0, 1, 1'b0, 1'b1, 1'b0,
                32'hFFFFF000, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0, 32'h01000000};
    vecs[3] = '{32'h0, 32'h0, 32'h0, -64'sd4096, 64'h0, 64'h0, 1, 1'b0, 1'b0, 1'b0,
                32'hFFFFF000, 32'h0, 32'h0, 16'hF000, 16'h0, 16'h0, 32'h0};
    vecs[4] = '{32'h0, 32'h0, 32'h0, 64'h0, 64'h10000, 64'h0, 1, 1'b0, 1'b0, 1'b0,
                32'h0, 32'h10000, 32'h0, 16'h0, 16'h7FFF, 16'h0, 32'h00800000};
    vecs[5] = '{32'h0, 32'h0, 32'h80000000, 64'h0, 64'h0, -64'sd1, 1, 1'b1, 1'b0, 1'b0,
                32'h0, 32'h0, 32'h7FFFFFFF, 16'h0, 16'h0, 16'h7FFF, 32'h02400000};
    vecs[6] = '{32'h0, 32'h0, 32'h0, 64'h0, 64'h0, 64'h7000, 1, 1'b0, 1'b1, 1'b1,
                32'h0, 32'h0, 32'h7000, 16'h0, 16'h0, 16'h7000, 32'h0};
    vecs[7] = '{32'h0, 32'h0, 32'h0, 64'h0, 64'h0, 64'h9000000, 1, 1'b0, 1'b1, 1'b1,
                32'h0, 32'h0, 32'h09000000, 16'h0, 16'h0, 16'h7FFF, 32'h00400000};

    for (int v = 0; v < 8; v++) begin
      tq0.delete(); tq1.delete(); tq2.delete();
      for (int i = 0; i < vecs[v].nt; i++) begin
        tq0.push_back(35'(vecs[v].t0));
        tq1.push_back(35'(vecs[v].t1));
        tq2.push_back(35'(vecs[v].t2));
      end
      exp_mac[0] = vecs[v].m0; exp_mac[1] = vecs[v].m1; exp_mac[2] = vecs[v].m2;
      exp_ir[0]  = vecs[v].r0; exp_ir[1]  = vecs[v].r1; exp_ir[2]  = vecs[v].r2;
      exp_flags  = vecs[v].fl;
      run_cmd(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].sf, vecs[v].lm, vecs[v].rtp,
              (v == 0) ? 2 : 0, $sformatf("vec%0d", v));
    end

    // Abort mid-ACC; the restart cycle's term (with last) must be dropped
    bus.i_start = 1'b1; bus.i_base0 = '0; bus.i_base1 = '0; bus.i_base2 = '0;
    bus.i_sf = 1'b0; bus.i_lm = 1'b0; bus.i_rtp = 1'b0;
    tick();
    bus.i_start = 1'b0;
    bus.i_termValid = 1'b1; bus.i_last = 1'b0;
    bus.i_term0 = 35'h5000; bus.i_term1 = '0; bus.i_term2 = '0;
    tick(); tick();
    bus.i_start = 1'b1; bus.i_last = 1'b1; bus.i_term0 = 35'h7777;
    tick();
    check("abort_busy", {31'b0, bus.o_busy}, 32'd1);
    check("abort_nodone", {31'b0, bus.o_done}, 32'd0);
    bus.i_start = 1'b0; bus.i_term0 = 35'h2000;
    tick();
    bus.i_termValid = 1'b0; bus.i_last = 1'b0;
    check("abort_done_early", {31'b0, bus.o_done}, 32'd0);
    tick();
    check("abort_done", {31'b0, bus.o_done}, 32'd1);
    check("abort_mac0", bus.o_mac0, 32'h2000);
    check("abort_ir0", {16'h0, bus.o_ir0}, 32'h2000);
    check("abort_flags", bus.o_flags, 32'h0);
    tick();

    // Terms while idle are ignored and results hold
    bus.i_termValid = 1'b1; bus.i_last = 1'b1; bus.i_term0 = 35'h123;
    repeat (3) tick();
    check("idle_busy", {31'b0, bus.o_busy}, 32'd0);
    check("idle_done", {31'b0, bus.o_done}, 32'd0);
    check("idle_hold", bus.o_mac0, 32'h2000);
    bus.i_termValid = 1'b0; bus.i_last = 1'b0;

    // Reset in the middle of a command
    bus.i_start = 1'b1; bus.i_base0 = 32'h1;
    tick();
    bus.i_start = 1'b0; bus.i_termValid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; bus.i_termValid = 1'b0;
    check("midrst_mac0", bus.o_mac0, 32'h0);
    check("midrst_busy", {31'b0, bus.o_busy}, 32'd0);
    tick();

    // Randomized commands against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      logic [31:0] b0, b1, b2;
      logic sf, lm, rtp;
      int nt;
      b0 = $urandom(); b1 = $urandom(); b2 = $urandom();
      if ($urandom_range(0, 1) == 1) b1 = 32'($signed($urandom_range(0, 2000)) - 1000);
      sf = 1'($urandom_range(0, 1));
      lm = 1'($urandom_range(0, 1));
      rtp = 1'($urandom_range(0, 1));
      nt = $urandom_range(1, 4);
      tq0.delete(); tq1.delete(); tq2.delete();
      for (int i = 0; i < nt; i++) begin
        tq0.push_back(rnd_term());
        tq1.push_back(rnd_term());
        tq2.push_back(rnd_term());
      end
      model(b0, b1, b2, sf, lm, rtp);
      run_cmd(b0, b1, b2, sf, lm, rtp, 2, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
